lsu: RTL

Load/store unit of the Cookabarra core, fed by the EX→MEM pipeline register and feeding the MEM→WB register. It turns load/store micro-ops into transactions on the core's data bus, aligns and extends load data, and forms byte enables and lane-shifted store data. It requests a pipeline stall until each transaction completes and raises misaligned and access-fault exceptions. All other micro-ops pass through combinationally.

---
 rtl/lsu.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu: Cookabarra load/store unit between the EX->MEM and MEM->WB pipeline registers.
// Optional feature macro LSU_MISALIGN_CHECK_EN: trap misaligned halfword/word accesses locally.
package lsu_pkg;
    localparam int ALU_OP_W = 8;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_NOP = 8'h00;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_ADD = 8'h01;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LB  = 8'h20;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LH  = 8'h21;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LW  = 8'h22;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LBU = 8'h23;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LHU = 8'h24;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_SB  = 8'h28;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_SH  = 8'h29;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_SW  = 8'h2A;
    localparam logic [31:0]         NOP_INST     = 32'h0000_0013;
endpackage

module lsu
    import lsu_pkg::*;
(
    input  logic                clk_i,
    input  logic                n_rst_i,
    input  logic                flush_i,
    input  logic                rd_we_i,
    input  logic [4:0]          rd_addr_i,
    input  logic [31:0]         rd_wdata_i,
    input  logic [ALU_OP_W-1:0] uopcode_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic                csr_we_i,
    input  logic [11:0]         csr_waddr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [31:0]         exception_i,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         inst_i,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic                data_err_i,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i,
    output logic                stallreq_o,
    output logic                rd_we_o,
    output logic [4:0]          rd_addr_o,
    output logic [31:0]         rd_wdata_o,
    output logic                csr_we_o,
    output logic [11:0]         csr_waddr_o,
    output logic [31:0]         csr_wdata_o,
    output logic [31:0]         exception_o,
    output logic [31:0]         pc_o,
    output logic [31:0]         inst_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ABORT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state, state_next;
    size_t       size;
    logic        is_load, is_store, is_mem, is_unsigned, misaligned, go, nop, bus_err;
    logic [3:0]  be;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] lane_wdata, load_ext, load_data, misalign_exc, access_exc;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
        size        = SZ_W;
        case (uopcode_i)
            UOP_CODE_LB:  begin is_load  = 1'b1; size = SZ_B; end
            UOP_CODE_LBU: begin is_load  = 1'b1; size = SZ_B; is_unsigned = 1'b1; end
            UOP_CODE_LH:  begin is_load  = 1'b1; size = SZ_H; end
            UOP_CODE_LHU: begin is_load  = 1'b1; size = SZ_H; is_unsigned = 1'b1; end
            UOP_CODE_LW:  is_load  = 1'b1;
            UOP_CODE_SB:  begin is_store = 1'b1; size = SZ_B; end
            UOP_CODE_SH:  begin is_store = 1'b1; size = SZ_H; end
            UOP_CODE_SW:  is_store = 1'b1;
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_mem && ((size == SZ_H && mem_addr_i[0]) ||
                                   (size == SZ_W && mem_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign misalign_exc = {24'b0, 1'b0, is_store & misaligned, 1'b0, is_load & misaligned, 4'b0};
    assign access_exc   = {24'b0, is_store & bus_err, 1'b0, is_load & bus_err, 5'b0};

    // Reset is folded in so the combinational IDLE request drops while reset is held.
    assign go = n_rst_i & ~flush_i & is_mem & (exception_i == 32'b0) & ~misaligned;

    always_comb begin
        case (size)
            SZ_B:    begin be = 4'b0001 << mem_addr_i[1:0];         lane_wdata = {4{mem_wdata_i[7:0]}};  end
            SZ_H:    begin be = 4'b0011 << {mem_addr_i[1], 1'b0};   lane_wdata = {2{mem_wdata_i[15:0]}}; end
            default: begin be = 4'b1111;                            lane_wdata = mem_wdata_i;            end
        endcase
    end

    assign rbyte = data_rdata_i[{mem_addr_i[1:0], 3'b000} +: 8];
    assign rhalf = data_rdata_i[{mem_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        case (size)
            SZ_B:    load_ext = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            SZ_H:    load_ext = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_ext = data_rdata_i;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            load_data <= 32'b0;
            bus_err   <= 1'b0;
        end else if (state == WAIT && data_rvalid_i) begin
            load_data <= load_ext;
            bus_err   <= data_err_i;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (go) state_next = data_gnt_i ? WAIT : REQ;
            REQ: begin
                if (data_gnt_i)   state_next = flush_i ? ABORT : WAIT;
                else if (flush_i) state_next = IDLE;
            end
            WAIT: begin
                if (data_rvalid_i) state_next = flush_i ? IDLE : DONE;
                else if (flush_i)  state_next = ABORT;
            end
            ABORT: if (data_rvalid_i) state_next = IDLE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_req_o   = 1'b0;
        stallreq_o   = 1'b0;
        data_we_o    = is_store;
        data_be_o    = be;
        data_addr_o  = {mem_addr_i[31:2], 2'b00};
        data_wdata_o = lane_wdata;
        rd_we_o      = rd_we_i;
        rd_addr_o    = rd_addr_i;
        rd_wdata_o   = rd_wdata_i;
        csr_we_o     = csr_we_i;
        csr_waddr_o  = csr_waddr_i;
        csr_wdata_o  = csr_wdata_i;
        exception_o  = exception_i;
        pc_o         = pc_i;
        inst_o       = inst_i;
        nop          = 1'b0;
        case (state)
            IDLE: begin
                if (flush_i) nop = 1'b1;
                else if (is_mem) begin
                    rd_we_o     = 1'b0;
                    exception_o = exception_i | misalign_exc;
                    data_req_o  = go;
                    stallreq_o  = go;
                end
            end
            REQ:   begin data_req_o = 1'b1; stallreq_o = 1'b1; rd_we_o = 1'b0; end
            WAIT:  begin stallreq_o = 1'b1; rd_we_o = 1'b0; end
            ABORT: begin stallreq_o = 1'b1; nop = 1'b1; end
            DONE: begin
                if (flush_i) nop = 1'b1;
                else begin
                    exception_o = exception_i | access_exc;
                    rd_we_o     = is_load & rd_we_i & ~bus_err;
                    if (is_load) rd_wdata_o = load_data;
                end
            end
            default: ;
        endcase
        if (nop) begin
            rd_we_o     = 1'b0;
            csr_we_o    = 1'b0;
            exception_o = 32'b0;
            inst_o      = NOP_INST;
        end
    end
endmodule
